// File: rtl/eau_len_scan_pkg.sv
// Shared EAU sizing: element count, length/sum widths and helper types.
// The tri-mux imports the same package so both sides agree on widths.
package eau_pkg;
    localparam int VLEN = 256;
    localparam int BSW  = 5;
    localparam int BS   = 1 << BSW;
    localparam int WW   = 8 - BSW + 1;
    localparam int PW   = BSW + WW;
    localparam int BLEN = BS * WW;

    typedef logic [WW-1:0] len_t;
    typedef logic [PW-1:0] sum_t;
    typedef logic [BSW:0]  cnt_t;

    // Element counts above BS are illegal; saturate rather than wrap.
    function automatic cnt_t clamp_num(input cnt_t n);
        return (n > cnt_t'(BS)) ? cnt_t'(BS) : n;
    endfunction
endpackage

// File: rtl/eau_scan_level.sv
// One registered Kogge-Stone level: s[i] += s[i-STRIDE] for i >= STRIDE.
// Valid, count and masked lengths ride along so every level stays aligned.
module eau_scan_level
    import eau_pkg::*;
#(
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [BSW:0]      in_num,
    input  logic [BLEN-1:0]   in_len,
    input  logic [BS*PW-1:0]  in_sum,
    output logic              out_valid,
    output logic [BSW:0]      out_num,
    output logic [BLEN-1:0]   out_len,
    output logic [BS*PW-1:0]  out_sum
);
    logic [BS*PW-1:0] nxt_sum;

    for (genvar i = 0; i < BS; i++) begin : g_elem
        if (i >= STRIDE) begin : g_add
            assign nxt_sum[i*PW +: PW] = in_sum[i*PW +: PW] + in_sum[(i-STRIDE)*PW +: PW];
        end else begin : g_pass
            assign nxt_sum[i*PW +: PW] = in_sum[i*PW +: PW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_num   <= '0;
            out_len   <= '0;
            out_sum   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_num   <= in_num;
            out_len   <= in_len;
            out_sum   <= nxt_sum;
        end
    end
endmodule

// File: rtl/eau_len_scan.sv
// Pipelined prefix-sum of per-element bit lengths: mask stage, BSW scan
// levels, then a finalize stage producing positions, fit count and overflow.
module eau_len_scan
    import eau_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BSW:0]      in_num,
    input  logic [BLEN-1:0]   in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BSW:0]      out_num,
    output logic [BLEN-1:0]   out_len,
    output logic [BS*PW-1:0]  out_psum,
    output logic [BS*PW-1:0]  out_pos,
    output logic [BSW:0]      out_fit,
    output logic              out_ovf
);
    // Handshake: a transfer happens on a clock edge where valid and ready are
    // both 1. The whole pipe advances as one (adv); in_ready mirrors adv, so a
    // held result also freezes every stage and nothing is dropped or repeated.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    cnt_t             num_c;
    logic [BLEN-1:0]  mask_len;
    logic [BS*PW-1:0] mask_sum;

    always_comb begin
        num_c    = clamp_num(in_num);
        mask_len = '0;
        mask_sum = '0;
        for (int i = 0; i < BS; i++) begin
            if (cnt_t'(i) < num_c) begin
                mask_len[i*WW +: WW] = in_len[i*WW +: WW];
                mask_sum[i*PW +: PW] = sum_t'(in_len[i*WW +: WW]);
            end
        end
    end

    logic             s0_valid;
    cnt_t             s0_num;
    logic [BLEN-1:0]  s0_len;
    logic [BS*PW-1:0] s0_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_num   <= '0;
            s0_len   <= '0;
            s0_sum   <= '0;
        end else if (adv) begin
            s0_valid <= in_valid;
            s0_num   <= num_c;
            s0_len   <= mask_len;
            s0_sum   <= mask_sum;
        end
    end

    logic             lv_valid [BSW+1];
    cnt_t             lv_num   [BSW+1];
    logic [BLEN-1:0]  lv_len   [BSW+1];
    logic [BS*PW-1:0] lv_sum   [BSW+1];

    assign lv_valid[0] = s0_valid;
    assign lv_num[0]   = s0_num;
    assign lv_len[0]   = s0_len;
    assign lv_sum[0]   = s0_sum;

    for (genvar j = 0; j < BSW; j++) begin : g_level
        eau_scan_level #(.STRIDE(1 << j)) u_level (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_valid  (lv_valid[j]),
            .in_num    (lv_num[j]),
            .in_len    (lv_len[j]),
            .in_sum    (lv_sum[j]),
            .out_valid (lv_valid[j+1]),
            .out_num   (lv_num[j+1]),
            .out_len   (lv_len[j+1]),
            .out_sum   (lv_sum[j+1])
        );
    end

    // psum is monotone, so the fit count is a popcount of live elements <= VLEN.
    logic [BS*PW-1:0] fin_pos;
    cnt_t             fin_fit;
    logic             fin_ovf;

    always_comb begin
        fin_pos = '0;
        fin_fit = '0;
        for (int i = 1; i < BS; i++) begin
            fin_pos[i*PW +: PW] = lv_sum[BSW][(i-1)*PW +: PW];
        end
        for (int i = 0; i < BS; i++) begin
            if (cnt_t'(i) < lv_num[BSW] && lv_sum[BSW][i*PW +: PW] <= sum_t'(VLEN)) begin
                fin_fit = fin_fit + cnt_t'(1);
            end
        end
        fin_ovf = lv_sum[BSW][(BS-1)*PW +: PW] > sum_t'(VLEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_num   <= '0;
            out_len   <= '0;
            out_psum  <= '0;
            out_pos   <= '0;
            out_fit   <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= lv_valid[BSW];
            out_num   <= lv_num[BSW];
            out_len   <= lv_len[BSW];
            out_psum  <= lv_sum[BSW];
            out_pos   <= fin_pos;
            out_fit   <= fin_fit;
            out_ovf   <= fin_ovf;
        end
    end
endmodule

// File: tb/tb_eau_len_scan.sv
// Self-checking bench for eau_len_scan: directed scenarios plus a random
// scoreboard run with output backpressure.
module tb_eau_len_scan;
    import eau_pkg::*;

    typedef struct packed {
        logic [BSW:0]     num;
        logic [BLEN-1:0]  len;
        logic [BS*PW-1:0] psum;
        logic [BS*PW-1:0] pos;
        logic [BSW:0]     fit;
        logic             ovf;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BSW:0]     in_num = '0;
    logic [BLEN-1:0]  in_len = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [BSW:0]     out_num;
    logic [BLEN-1:0]  out_len;
    logic [BS*PW-1:0] out_psum;
    logic [BS*PW-1:0] out_pos;
    logic [BSW:0]     out_fit;
    logic             out_ovf;

    int   checks = 0;
    int   errors = 0;
    int   stall_pct = 0;
    res_t exp_q[$];
    res_t obs_q[$];

    eau_len_scan dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_len   (out_len),
        .out_psum  (out_psum),
        .out_pos   (out_pos),
        .out_fit   (out_fit),
        .out_ovf   (out_ovf)
    );

    // ---------------- clock / reset / background processes ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (stall_pct > 0) out_ready = ($urandom_range(0, 99) >= stall_pct);
    end

    function automatic res_t cur_out();
        res_t r;
        r.num = out_num; r.len = out_len; r.psum = out_psum;
        r.pos = out_pos; r.fit = out_fit; r.ovf = out_ovf;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs_q.push_back(cur_out());
    end

    // ---------------- reference model ----------------
    function automatic res_t model(input cnt_t n, input logic [BLEN-1:0] l);
        res_t r;
        int nn, acc, v;
        r   = '0;
        nn  = (int'(n) > BS) ? BS : int'(n);
        r.num = cnt_t'(nn);
        acc = 0;
        for (int i = 0; i < BS; i++) begin
            r.pos[i*PW +: PW] = sum_t'(acc);
            v = (i < nn) ? int'(l[i*WW +: WW]) : 0;
            r.len[i*WW +: WW] = len_t'(v);
            acc = acc + v;
            r.psum[i*PW +: PW] = sum_t'(acc);
            if (i < nn && acc <= VLEN) r.fit = r.fit + 1'b1;
        end
        r.ovf = (acc > VLEN);
        return r;
    endfunction

    function automatic logic [BLEN-1:0] rand_len();
        logic [BLEN-1:0] l;
        for (int i = 0; i < BS; i++) l[i*WW +: WW] = len_t'($urandom_range(0, (1 << WW) - 1));
        return l;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int n, input logic [BLEN-1:0] l);
        int g;
        in_valid = 1'b1;
        in_num   = cnt_t'(n);
        in_len   = l;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready stuck got=%0b exp=1", in_ready);
        end
        exp_q.push_back(model(cnt_t'(n), l));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (obs_q.size() < exp_q.size() && g < 600) begin
            @(posedge clk);
            g++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, cur_out()} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid, cur_out()});
        end
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic test_basic();
        int v[8] = '{4, 6, 3, 2, 2, 3, 5, 0};
        logic [BLEN-1:0] l;
        int lat;
        res_t e, o;
        l = rand_len();
        for (int i = 0; i < 8; i++) l[i*WW +: WW] = len_t'(v[i]);
        send(7, l);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=7", lat);
        end
        o = cur_out();
        checks++;
        if (o.fit !== 7 || o.ovf !== 1'b0 || o.psum[6*PW +: PW] !== 25 || o.pos[6*PW +: PW] !== 20) begin
            errors++;
            $display("FAIL basic_fields fit=%0d ovf=%0b psum6=%0d pos6=%0d exp 7 0 25 20",
                     o.fit, o.ovf, o.psum[6*PW +: PW], o.pos[6*PW +: PW]);
        end
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL basic_result got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_masking();
        int v[5] = '{4, 6, 3, 2, 2};
        logic [BLEN-1:0] l;
        res_t e, o;
        l = rand_len();
        for (int i = 0; i < 5; i++) l[i*WW +: WW] = len_t'(v[i]);
        send(3, l);
        send(45, {BS{len_t'(1)}});
        drain();
        if (obs_q.size() > 1) begin
            checks++;
            if (obs_q[0].len[BLEN-1:3*WW] !== '0 || obs_q[0].fit !== 3 || obs_q[0].psum[(BS-1)*PW +: PW] !== 13) begin
                errors++;
                $display("FAIL mask_fields fit=%0d psum31=%0d exp 3 13", obs_q[0].fit, obs_q[0].psum[(BS-1)*PW +: PW]);
            end
            checks++;
            if (obs_q[1].num !== BS || obs_q[1].fit !== BS) begin
                errors++;
                $display("FAIL mask_clamp num=%0d fit=%0d exp %0d", obs_q[1].num, obs_q[1].fit, BS);
            end
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL mask_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL mask_result got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow();
        res_t e, o;
        send(BS, {BS{len_t'(15)}});
        send(BS, {BS{len_t'(8)}});
        drain();
        if (obs_q.size() > 1) begin
            checks++;
            if (obs_q[0].psum[(BS-1)*PW +: PW] !== 480 || obs_q[0].fit !== 17 || obs_q[0].ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_15 psum31=%0d fit=%0d ovf=%0b exp 480 17 1",
                         obs_q[0].psum[(BS-1)*PW +: PW], obs_q[0].fit, obs_q[0].ovf);
            end
            checks++;
            if (obs_q[1].psum[(BS-1)*PW +: PW] !== 256 || obs_q[1].fit !== 32 || obs_q[1].ovf !== 1'b0) begin
                errors++;
                $display("FAIL ovf_equal psum31=%0d fit=%0d ovf=%0b exp 256 32 0",
                         obs_q[1].psum[(BS-1)*PW +: PW], obs_q[1].fit, obs_q[1].ovf);
            end
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL ovf_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ovf_result got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_empty();
        res_t o;
        send(0, rand_len());
        drain();
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL empty_count got=%0d exp=1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== '0) begin errors++; $display("FAIL empty_result got=%h exp=0", o); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        res_t e, o, snap;
        fork
            begin
                for (int k = 0; k < 10; k++) send($urandom_range(1, BS), rand_len());
            end
            begin
                int g;
                g = 0;
                while (!out_valid && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                @(posedge clk); #1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                snap = cur_out();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (cur_out() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold cyc=%0d valid=%0b in_ready=%0b held=%0b exp 1 0 1",
                                 k, out_valid, in_ready, cur_out() === snap);
                    end
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (obs_q.size() !== 10 || exp_q.size() !== 10) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL bp_result got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        res_t e, o;
        int run;
        run = 0;
        fork
            begin
                for (int k = 0; k < 32; k++) send((k % 5 == 0) ? 0 : $urandom_range(1, BS), rand_len());
            end
            begin
                int g;
                g = 0;
                @(negedge clk);
                while (!out_valid && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                while (out_valid && run < 100) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (run !== 32) begin
            errors++;
            $display("FAIL b2b_run got=%0d exp=32", run);
        end
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_result got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        res_t e, o;
        int lat;
        for (int k = 0; k < 4; k++) send($urandom_range(1, BS), rand_len());
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, cur_out()} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%h exp=0", {out_valid, cur_out()});
        end
        rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        send($urandom_range(1, BS), rand_len());
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL rstmid_latency got=%0d exp=7", lat);
        end
        drain();
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL rstmid_count got=%0d exp=1", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rstmid_result got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        res_t e, o;
        int n;
        stall_pct = 25;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(BS + 1, 2 * BS - 1) : $urandom_range(0, BS);
            send(n, rand_len());
        end
        drain();
        stall_pct = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rand_result got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_masking();
        test_overflow();
        test_empty();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
